axi_user_port_arbiter: RTL and testbench
========================================

Name: axi_user_port_arbiter

Overview:
- Shares the single AXI burst-master user port (start/free/stall handshake) between NUM_REQ independent requesters.
- Arbitrates round-robin and launches one command per grant.
- Muxes write data to the master and routes read data and stalls back to the owning requester.
- Holds ownership until the master reports free again, then signals completion and status to that requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data width
- BLEN_W, 4, burst length field width (beats = value+1)
- STRB_W, DATA_W/8, byte-strobe width
- BUSY_TIMEOUT, 16, max cycles from m_start until m_free must fall

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; the single clock is aclk, reset is synchronous and active-low
- req_valid  in  NUM_REQ  command pending; held high until req_ack
- req_w_r  in  NUM_REQ  0=write, 1=read
- req_addr  in  NUM_REQ*ADDR_W  start address, flattened, requester i at [i*ADDR_W +: ADDR_W]
- req_burst_len  in  NUM_REQ*BLEN_W  burst length-1
- req_strb  in  NUM_REQ*STRB_W  write strobe for whole burst
- req_wdata  in  NUM_REQ*DATA_W  live write data
- req_ack  out  NUM_REQ  1-cycle pulse, command launched
- req_grant  out  NUM_REQ  one-hot owner, ack through done inclusive
- req_done  out  NUM_REQ  1-cycle pulse, transaction finished
- req_status  out  2  status of last finished transaction, valid with req_done
- req_rdata  out  DATA_W  read data broadcast (= m_data_out)
- req_rdata_en  out  NUM_REQ  read beat strobe, owner only
- req_stall_w  out  NUM_REQ  write-data stall per requester
- req_stall_r  out  NUM_REQ  read-data stall per requester
- err_timeout  out  1  1-cycle pulse on busy timeout
- m_start  out  1  master start pulse
- m_w_r  out  1  to master
- m_addr  out  ADDR_W  to master
- m_burst_len  out  BLEN_W  to master
- m_strb  out  STRB_W  to master
- m_wdata  out  DATA_W  to master
- m_free  in  1  master idle
- m_stall_w_data  in  1  master write stall
- m_stall_r_data  in  1  master read stall
- m_data_out  in  DATA_W  master read data
- m_data_out_en  in  1  master read beat valid
- m_status  in  2  master response status

Behaviour:
- FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |req_valid and m_free: round-robin pick, searching from rr_ptr+1 upward mod NUM_REQ.
  - Latch winner's w_r, addr, burst_len, strb into the m_* registers.
  - Set owner; go to ISSUE.
- ISSUE (exactly 1 cycle): m_start=1 and req_ack[owner]=1 (registered); req_grant[owner]=1 from here; go to WAIT_BUSY. Latency from sampled req_valid to m_start is 1 cycle.
- WAIT_BUSY:
  - m_free==0 → WAIT_DONE, counter cleared.
  - Otherwise the counter increments; at count==BUSY_TIMEOUT: req_done[owner]=1, req_status=2'b10, err_timeout=1; go to IDLE.
- WAIT_DONE:
  - m_free==1 → req_done[owner]=1, req_status=m_status sampled that cycle; rr_ptr=owner; go to IDLE.
  - A new grant can be evaluated in the following IDLE cycle, so the minimum gap between commands is 1 idle cycle.
- req_grant clears in the cycle after req_done.
- m_wdata = req_wdata[owner] combinationally while owned; 0 otherwise. m_addr, m_burst_len, m_strb, m_w_r stay stable from latch until next latch.
- Stalls and read data:
  - req_stall_w[owner]=m_stall_w_data and req_stall_r[owner]=m_stall_r_data; all non-owners and all requesters in IDLE see 1.
  - req_rdata_en[owner]=m_data_out_en; 0 for others.
- req_valid deasserting before ack is ignored; the grant is only decided in IDLE.
- Simultaneous requests: exactly one winner per arbitration; a requester loses at most NUM_REQ-1 consecutive arbitrations.
- Reset (any state, including mid-burst), all synchronous:
  - m_start=0, m_w_r=0, m_addr=0, m_burst_len=0, m_strb=0, req_ack=0, req_grant=0, req_done=0, req_status=0, err_timeout=0, req_rdata_en=0.
  - req_stall_w and req_stall_r all 1.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority. FSM→IDLE.
  - No protection of the master's in-flight burst: the master shares aresetn.

Decomposition:
- Package axi_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
  - status constants STAT_OKAY=2'b00, STAT_TIMEOUT=2'b10.
  - Default widths.
- Sub-module rr_arbiter: combinational round-robin priority select.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and binary index.
  - Parameter NUM_REQ.

Test Plan:
- Single write: req_valid[0]=1, addr 0x10000000, len 0, strb 0xFF → m_start 1 cycle after; req_ack[0] same cycle; req_done[0] when m_free rises; req_status=00.
- All four request at once (reads, len 15) → grants in order 0,1,2,3, each owning 16 rdata_en beats; non-owners see req_stall_r=1 and rdata_en=0 throughout.
- Requester 2 re-requests continuously against 0 and 3 → order 0,2,3,0,2,3; no requester is starved.
- Write burst len 15 from requester 1, strb 0x0F → m_strb=0x0F and m_addr held for the whole burst; m_wdata tracks req_wdata[1] each beat; req_stall_w[1] mirrors m_stall_w_data.
- Master holds m_free=1 after m_start → after 16 cycles: req_done pulse, req_status=10, err_timeout=1, return to IDLE.
- aresetn=0 during WAIT_DONE on a len 15 read → next cycle all outputs at reset values; after release, requester 0 wins first.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the AXI user-port arbiter.
package axi_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_e;

  localparam logic [1:0] STAT_OKAY    = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_BLEN_W       = 4;
  localparam int DEF_BUSY_TIMEOUT = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: searches upward from rr_ptr+1, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      if (!found && req[sum[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[sum[IDX_W-1:0]]    = 1'b1;
        grant_idx                = sum[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/axi_user_port_arbiter.sv
// Shares one burst-master user port between NUM_REQ requesters; one command per grant,
// ownership held until the master goes free again.
module axi_user_port_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BLEN_W       = DEF_BLEN_W,
  parameter int STRB_W       = DATA_W / 8,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_w_r,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*BLEN_W-1:0]  req_burst_len,
  input  logic [NUM_REQ*STRB_W-1:0]  req_strb,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [1:0]                 req_status,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [NUM_REQ-1:0]         req_rdata_en,
  output logic [NUM_REQ-1:0]         req_stall_w,
  output logic [NUM_REQ-1:0]         req_stall_r,
  output logic                       err_timeout,
  output logic                       m_start,
  output logic                       m_w_r,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [BLEN_W-1:0]          m_burst_len,
  output logic [STRB_W-1:0]          m_strb,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_free,
  input  logic                       m_stall_w_data,
  input  logic                       m_stall_r_data,
  input  logic [DATA_W-1:0]          m_data_out,
  input  logic                       m_data_out_en,
  input  logic [1:0]                 m_status
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, win_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] win_oh, owner_oh;
  logic [NUM_REQ-1:0] ack_q, ack_d, grant_q, grant_d, done_q, done_d;
  logic [1:0]         status_q, status_d;
  logic               err_q, err_d, m_start_q, m_start_d, m_w_r_q, m_w_r_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [BLEN_W-1:0]  m_blen_q, m_blen_d;
  logic [STRB_W-1:0]  m_strb_q, m_strb_d;
  logic               owned;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (win_oh),
    .grant_idx (win_idx)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign owned    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    m_start_d = 1'b0;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    status_d  = status_q;
    grant_d   = done_q ? '0 : grant_q;
    m_w_r_d   = m_w_r_q;
    m_addr_d  = m_addr_q;
    m_blen_d  = m_blen_q;
    m_strb_d  = m_strb_q;
    case (state_q)
      IDLE: begin
        if (|req_valid && m_free) begin
          state_d   = ISSUE;
          owner_d   = win_idx;
          m_w_r_d   = req_w_r[win_idx];
          m_addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          m_blen_d  = req_burst_len[win_idx*BLEN_W +: BLEN_W];
          m_strb_d  = req_strb[win_idx*STRB_W +: STRB_W];
          m_start_d = 1'b1;
          ack_d     = win_oh;
          grant_d   = win_oh;
          cnt_d     = '0;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!m_free) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Master never acknowledged the start: release the port and flag it.
          done_d   = owner_oh;
          status_d = STAT_TIMEOUT;
          err_d    = 1'b1;
          rr_ptr_d = owner_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (m_free) begin
          done_d   = owner_oh;
          status_d = m_status;
          rr_ptr_d = owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      m_start_q <= 1'b0;
      ack_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      status_q  <= STAT_OKAY;
      err_q     <= 1'b0;
      m_w_r_q   <= 1'b0;
      m_addr_q  <= '0;
      m_blen_q  <= '0;
      m_strb_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      m_start_q <= m_start_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      status_q  <= status_d;
      err_q     <= err_d;
      m_w_r_q   <= m_w_r_d;
      m_addr_q  <= m_addr_d;
      m_blen_q  <= m_blen_d;
      m_strb_q  <= m_strb_d;
    end
  end

  // Data-path routing follows the FSM, not req_grant, so the done cycle is already idle.
  always_comb begin
    req_stall_w  = '1;
    req_stall_r  = '1;
    req_rdata_en = '0;
    m_wdata      = '0;
    if (owned) begin
      req_stall_w[owner_q]  = m_stall_w_data;
      req_stall_r[owner_q]  = m_stall_r_data;
      req_rdata_en[owner_q] = m_data_out_en;
      m_wdata               = req_wdata[owner_q*DATA_W +: DATA_W];
    end
  end

  assign req_rdata   = m_data_out;
  assign req_ack     = ack_q;
  assign req_grant   = grant_q;
  assign req_done    = done_q;
  assign req_status  = status_q;
  assign err_timeout = err_q;
  assign m_start     = m_start_q;
  assign m_w_r       = m_w_r_q;
  assign m_addr      = m_addr_q;
  assign m_burst_len = m_blen_q;
  assign m_strb      = m_strb_q;
endmodule

// File: tb/tb_axi_user_port_arbiter.sv
// Scoreboard bench: directed requests push expected launches/completions; a monitor checks them.
module tb_axi_user_port_arbiter;
  localparam int N = 4, AW = 32, DW = 64, BW = 4, SW = 8, TO = 16;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [N-1:0]    req_valid, req_w_r, req_ack, req_grant, req_done;
  logic [N-1:0]    req_rdata_en, req_stall_w, req_stall_r;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_burst_len;
  logic [N*SW-1:0] req_strb;
  logic [N*DW-1:0] req_wdata;
  logic [1:0]      req_status, m_status;
  logic [DW-1:0]   req_rdata, m_wdata, m_data_out;
  logic            err_timeout, m_start, m_w_r, m_free, m_stall_w_data, m_stall_r_data, m_data_out_en;
  logic [AW-1:0]   m_addr;
  logic [BW-1:0]   m_burst_len;
  logic [SW-1:0]   m_strb;

  axi_user_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW),
                          .STRB_W(SW), .BUSY_TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_w_r(req_w_r), .req_addr(req_addr),
    .req_burst_len(req_burst_len), .req_strb(req_strb), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_grant(req_grant), .req_done(req_done), .req_status(req_status),
    .req_rdata(req_rdata), .req_rdata_en(req_rdata_en),
    .req_stall_w(req_stall_w), .req_stall_r(req_stall_r), .err_timeout(err_timeout),
    .m_start(m_start), .m_w_r(m_w_r), .m_addr(m_addr), .m_burst_len(m_burst_len),
    .m_strb(m_strb), .m_wdata(m_wdata), .m_free(m_free),
    .m_stall_w_data(m_stall_w_data), .m_stall_r_data(m_stall_r_data),
    .m_data_out(m_data_out), .m_data_out_en(m_data_out_en), .m_status(m_status)
  );

  typedef struct {
    int own; bit wr; logic [AW-1:0] addr; logic [BW-1:0] bl; logic [SW-1:0] sb;
    logic [1:0] st; bit err; int beats; int lat;
  } exp_t;

  exp_t lq[$], dq[$];
  int   li = 0, di = 0;
  int   n_cmp = 0, n_bad = 0;
  int   cyc, tmo;
  int   rereq[N];
  bit   fin, mst_hang;
  logic [1:0] mst_status;

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge aclk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      req_wdata[i*DW +: DW] = {cyc, i};
      if (req_ack[i]) begin
        if (rereq[i] > 0) rereq[i]--;
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] bl, input logic [SW-1:0] sb, input int rr);
    req_w_r[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_burst_len[i*BW +: BW] = bl;
    req_strb[i*SW +: SW] = sb;
    rereq[i] = rr;
    req_valid[i] = 1'b1;
  endtask

  task automatic exp_launch(input int o, input bit wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] bl, input logic [SW-1:0] sb);
    exp_t e;
    e = '{default: 0};
    e.own = o; e.wr = wr; e.addr = a; e.bl = bl; e.sb = sb;
    lq.push_back(e);
  endtask

  task automatic exp_done(input int o, input logic [1:0] st, input bit err, input int beats, input int lat);
    exp_t e;
    e = '{default: 0};
    e.own = o; e.st = st; e.err = err; e.beats = beats; e.lat = lat;
    dq.push_back(e);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((di != dq.size() || li != lq.size() || |req_valid) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      $display("FAIL wait_idle: no completion within %0d cycles (launch %0d/%0d done %0d/%0d)",
               lim, li, lq.size(), di, dq.size());
      tmo++;
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    int ord[6];
    aresetn = 1'b0; req_valid = '0; req_w_r = '0; req_addr = '0; req_burst_len = '0;
    req_strb = '0; req_wdata = '0; cyc = 0; tmo = 0; fin = 1'b0; mst_hang = 1'b0; mst_status = 2'b00;
    for (int i = 0; i < N; i++) rereq[i] = 0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // single write from requester 0
    set_req(0, 1'b0, 32'h1000_0000, 4'd0, 8'hFF, 0);
    exp_launch(0, 1'b0, 32'h1000_0000, 4'd0, 8'hFF);
    exp_done(0, 2'b00, 1'b0, 0, 0);
    wait_idle(100);

    // fresh priority, then all four request 16-beat reads at once
    do_reset();
    mst_status = 2'b01;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 32'h2000_0000 + 32'(i * 256), 4'd15, 8'(8'h11 << i), 0);
      exp_launch(i, 1'b1, 32'h2000_0000 + 32'(i * 256), 4'd15, 8'(8'h11 << i));
      exp_done(i, 2'b01, 1'b0, 16, 0);
    end
    wait_idle(400);
    mst_status = 2'b00;

    // 0, 2, 3 each issue two commands back to back; pointer is at 3
    ord = '{0, 2, 3, 0, 2, 3};
    set_req(0, 1'b0, 32'h5000_0000, 4'd1, 8'hFF, 1);
    set_req(2, 1'b0, 32'h5000_0020, 4'd1, 8'hFF, 1);
    set_req(3, 1'b0, 32'h5000_0030, 4'd1, 8'hFF, 1);
    for (int k = 0; k < 6; k++) begin
      exp_launch(ord[k], 1'b0, 32'h5000_0000 + 32'(ord[k] * 16), 4'd1, 8'hFF);
      exp_done(ord[k], 2'b00, 1'b0, 0, 0);
    end
    wait_idle(300);

    // 16-beat write from requester 1 with partial strobe
    set_req(1, 1'b0, 32'h3000_0040, 4'd15, 8'h0F, 0);
    exp_launch(1, 1'b0, 32'h3000_0040, 4'd15, 8'h0F);
    exp_done(1, 2'b00, 1'b0, 0, 0);
    wait_idle(200);

    // master never goes busy: timeout
    mst_hang = 1'b1;
    set_req(3, 1'b1, 32'h4000_0000, 4'd3, 8'hFF, 0);
    exp_launch(3, 1'b1, 32'h4000_0000, 4'd3, 8'hFF);
    exp_done(3, 2'b10, 1'b1, 0, TO + 1);
    wait_idle(100);
    mst_hang = 1'b0;

    // reset in the middle of a read burst; the aborted command never completes
    set_req(2, 1'b1, 32'h6000_0000, 4'd15, 8'hFF, 0);
    exp_launch(2, 1'b1, 32'h6000_0000, 4'd15, 8'hFF);
    repeat (8) tick();
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    set_req(1, 1'b0, 32'h7000_0100, 4'd0, 8'hC3, 0);
    set_req(0, 1'b0, 32'h7000_0000, 4'd0, 8'h3C, 0);
    exp_launch(0, 1'b0, 32'h7000_0000, 4'd0, 8'h3C);
    exp_done(0, 2'b00, 1'b0, 0, 0);
    exp_launch(1, 1'b0, 32'h7000_0100, 4'd0, 8'hC3);
    exp_done(1, 2'b00, 1'b0, 0, 0);
    wait_idle(100);

    fin = 1'b1;
    repeat (20) tick();
    $display("FAIL monitor: no summary reached");
    $fatal(1, "bench stalled");
  end

  // ---------------- master model ----------------
  initial begin : mst
    int n, b, ph;
    bit wr, stl;
    m_free = 1'b1; m_stall_w_data = 1'b0; m_stall_r_data = 1'b0;
    m_data_out = '0; m_data_out_en = 1'b0; m_status = 2'b00; ph = 0;
    forever begin
      @(negedge aclk);
      if (aresetn && m_start && !mst_hang) begin
        wr = m_w_r; n = int'(m_burst_len) + 1; b = 0;
        m_free = 1'b0;
        while (b < n) begin
          @(negedge aclk);
          if (!aresetn) break;
          ph++;
          stl = (ph % 4 == 2);
          if (wr) begin
            m_stall_r_data = stl;
            m_data_out_en  = !stl;
            m_data_out     = {ph, b};
          end else begin
            m_stall_w_data = stl;
          end
          if (!stl) b++;
        end
        if (aresetn) @(negedge aclk);
        m_data_out_en = 1'b0; m_stall_w_data = 1'b0; m_stall_r_data = 1'b0;
        m_status = mst_status; m_free = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin : mon
    bit busy, gon, gclr;
    int own, beats, lat;
    exp_t e;
    logic [AW-1:0] h_addr; logic [BW-1:0] h_bl; logic [SW-1:0] h_sb; logic h_wr;
    logic [N-1:0] oh, ev_w, ev_r, ev_en, eg;
    logic [DW-1:0] ewd;
    busy = 0; gon = 0; gclr = 0; own = 0; beats = 0; lat = 0;
    h_addr = '0; h_bl = '0; h_sb = '0; h_wr = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (fin) begin
        chk("bounded_waits", tmo, 0);
        chk("launch_drain", li, lq.size());
        chk("done_drain", di, dq.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (!aresetn) begin
        busy = 0; gon = 0; gclr = 0;
        h_addr = '0; h_bl = '0; h_sb = '0; h_wr = 1'b0;
        chk("reset_outs", {m_start, m_w_r, m_addr, m_burst_len, m_strb, req_ack, req_grant,
                           req_done, req_status, err_timeout, req_rdata_en}, '0);
        chk("reset_wdata", m_wdata, '0);
        chk("reset_stalls", {req_stall_w, req_stall_r}, {N{2'b11}});
        continue;
      end
      if (gclr) begin gon = 0; gclr = 0; end
      if (busy) begin
        lat++;
        if (req_rdata_en[own]) beats++;
      end
      if (|req_done || err_timeout) begin
        busy = 0; gclr = 1;
        if (di >= dq.size()) chk("done_expected", {err_timeout, req_done}, '0);
        else begin
          e = dq[di]; di++;
          oh = N'(1) << e.own;
          chk("done_vec", req_done, oh);
          chk("done_status", req_status, e.st);
          chk("done_err", err_timeout, e.err);
          chk("done_beats", beats, e.beats);
          if (e.lat != 0) chk("done_latency", lat, e.lat);
        end
      end
      if (m_start || |req_ack) begin
        if (li >= lq.size()) chk("launch_expected", {m_start, req_ack}, '0);
        else begin
          e = lq[li]; li++;
          oh = N'(1) << e.own;
          chk("launch_ack", {m_start, req_ack}, {1'b1, oh});
          chk("launch_cmd", {m_w_r, m_addr, m_burst_len, m_strb}, {e.wr, e.addr, e.bl, e.sb});
          own = e.own; h_wr = e.wr; h_addr = e.addr; h_bl = e.bl; h_sb = e.sb;
          busy = 1; gon = 1; gclr = 0; beats = 0; lat = 0;
        end
      end
      oh    = N'(1) << own;
      eg    = gon ? oh : '0;
      ev_w  = '1; ev_r = '1; ev_en = '0;
      ewd   = '0;
      if (busy) begin
        ev_w[own]  = m_stall_w_data;
        ev_r[own]  = m_stall_r_data;
        ev_en[own] = m_data_out_en;
        ewd        = req_wdata[own*DW +: DW];
      end
      chk("cmd_hold", {m_w_r, m_addr, m_burst_len, m_strb}, {h_wr, h_addr, h_bl, h_sb});
      chk("grant", req_grant, eg);
      chk("stall_w", req_stall_w, ev_w);
      chk("stall_r", req_stall_r, ev_r);
      chk("rdata_en", req_rdata_en, ev_en);
      chk("wdata", m_wdata, ewd);
      chk("rdata", req_rdata, m_data_out);
    end
  end
endmodule
